// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin arbiter in front of m_fluxo:
// FSM encoding, requester count and one-hot/index helpers.
package arbitro_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    OCIOSO    = 1'b0,
    CONCEDIDO = 1'b1
  } estado_t;

  // Binary requester index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  // One-hot grant vector back to a binary index (zero for an all-zero vector).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/m_fluxo.sv
// 4:1 single-bit multiplexer shared by the four requesters.
module m_fluxo (
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic s1,
  input  logic s0,
  output logic y
);

  // Select one data bit from the {s1,s0} index.
  always_comb begin
    unique case ({s1, s0})
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_prioridade.sv
// Combinational round-robin priority picker: first unmasked requester
// found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_prioridade
  import arbitro_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             achou,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] elegivel;
  logic [IDX_W-1:0] cand;

  assign elegivel = req & ~mask;

  // Scan from the farthest offset down so the closest-to-ptr winner is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    achou = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (elegivel[cand]) begin
        achou = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_mux.sv
// Round-robin arbiter for the m_fluxo mux: one-hot registered grant,
// mux selects from the owner index, hold limit of MAX_HOLD cycles per grant.
module arbitro_mux
  import arbitro_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             s1,
  output logic             s0,
  output logic             valid,
  output logic [CW-1:0]    cnt
);

  estado_t          estado_q, estado_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] dono_q, dono_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] mask;
  logic             achou;
  logic [IDX_W-1:0] vencedor;
  logic             dono_pede;
  logic             no_limite;

  // While granted the owner is masked so a release arbitrates among the others.
  assign mask      = (estado_q == CONCEDIDO) ? idx_to_onehot(dono_q) : '0;
  assign dono_pede = req[dono_q];
  assign no_limite = (cnt_q == CW'(MAX_HOLD - 1));

  rr_prioridade u_prioridade (
    .req   (req),
    .ptr   (ptr_q),
    .mask  (mask),
    .achou (achou),
    .idx   (vencedor)
  );

  // Next-state logic: grant, keep, hand off, re-grant on timeout, or go idle.
  always_comb begin
    estado_d = estado_q;
    ptr_d    = ptr_q;
    dono_d   = dono_q;
    gnt_d    = gnt_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    unique case (estado_q)
      OCIOSO: begin
        if (achou) begin
          estado_d = CONCEDIDO;
          dono_d   = vencedor;
          gnt_d    = idx_to_onehot(vencedor);
          valid_d  = 1'b1;
          cnt_d    = '0;
          ptr_d    = vencedor + 1'b1;
        end
      end
      CONCEDIDO: begin
        if (dono_pede && !no_limite) begin
          cnt_d = cnt_q + CW'(1);
        end else if (achou) begin
          dono_d = vencedor;
          gnt_d  = idx_to_onehot(vencedor);
          cnt_d  = '0;
          ptr_d  = vencedor + 1'b1;
        end else if (dono_pede) begin
          // Timeout with nobody else waiting: the owner simply starts a new grant.
          cnt_d = '0;
          ptr_d = dono_q + 1'b1;
        end else begin
          estado_d = OCIOSO;
          gnt_d    = '0;
          valid_d  = 1'b0;
          cnt_d    = '0;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      ptr_q    <= '0;
      dono_q   <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      estado_q <= estado_d;
      ptr_q    <= ptr_d;
      dono_q   <= dono_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign cnt   = cnt_q;
  assign s1    = dono_q[1];
  assign s0    = dono_q[0];

endmodule

// File: tb/tb_arbitro_mux.sv
// Self-checking bench: three arbiters (MAX_HOLD 8, 2, 1) share one request
// stream and are compared every cycle against a behavioural round-robin model;
// the MAX_HOLD=1 instance also drives m_fluxo to check y end to end.
module tb_arbitro_mux;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] dv;

  logic [3:0] gnt   [3];
  logic       s1    [3];
  logic       s0    [3];
  logic       valid [3];
  logic [7:0] cnt   [3];
  logic       y;

  int n_checks;
  int n_errors;

  // Behavioural model state, one entry per instance.
  int hold   [3] = '{8, 2, 1};
  int m_own  [3];
  int m_cnt  [3];
  int m_prio [3];
  bit m_busy [3];

  arbitro_mux #(.MAX_HOLD(8), .CW(8)) dut_h8 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt[0]),
    .s1(s1[0]), .s0(s0[0]), .valid(valid[0]), .cnt(cnt[0])
  );
  arbitro_mux #(.MAX_HOLD(2), .CW(8)) dut_h2 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt[1]),
    .s1(s1[1]), .s0(s0[1]), .valid(valid[1]), .cnt(cnt[1])
  );
  arbitro_mux #(.MAX_HOLD(1), .CW(8)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt[2]),
    .s1(s1[2]), .s0(s0[2]), .valid(valid[2]), .cnt(cnt[2])
  );
  m_fluxo u_mux (
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .s1(s1[2]), .s0(s0[2]), .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_own[i] = 0; m_cnt[i] = 0; m_prio[i] = 0; m_busy[i] = 1'b0;
    end
  endtask

  // One clock of the arbitration rules for instance i under request vector r.
  task automatic model_step(input int i, input logic [3:0] r);
    int win;
    if (m_busy[i] && r[m_own[i]] && (m_cnt[i] < hold[i] - 1)) begin
      m_cnt[i]++;
    end else begin
      win = -1;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_prio[i] + k) % 4;
        if (win < 0 && r[c] && !(m_busy[i] && c == m_own[i])) win = c;
      end
      if (win < 0 && m_busy[i] && r[m_own[i]]) win = m_own[i];
      if (win >= 0) begin
        m_busy[i] = 1'b1;
        m_own[i]  = win;
        m_cnt[i]  = 0;
        m_prio[i] = (win + 1) % 4;
      end else begin
        m_busy[i] = 1'b0;
        m_cnt[i]  = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] eg;
      logic [1:0] eo;
      eg = m_busy[i] ? (4'b0001 << m_own[i]) : 4'b0000;
      eo = m_own[i][1:0];
      check($sformatf("i%0d gnt", i),   32'(gnt[i]),          32'(eg));
      check($sformatf("i%0d valid", i), 32'(valid[i]),        32'(m_busy[i]));
      check($sformatf("i%0d sel", i),   32'({s1[i], s0[i]}),  32'(eo));
      check($sformatf("i%0d cnt", i),   32'(cnt[i]),          32'(m_cnt[i]));
    end
    if (m_busy[2]) check("y", 32'(y), 32'(dv[m_own[2]]));
  endtask

  // Drive inputs (at negedge), let one rising edge pass, then compare at the next negedge.
  task automatic step(input logic [3:0] r, input logic [3:0] d);
    req = r;
    dv  = d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, r);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    req   = 4'b0000;
    dv    = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester for three cycles, then release.
    for (int n = 0; n < 3; n++) step(4'b0100, 4'b0000);
    check("single gnt", 32'(gnt[0]), 32'h4);
    check("single sel", 32'({s1[0], s0[0]}), 32'h2);
    check("single cnt", 32'(cnt[0]), 32'd2);
    step(4'b0000, 4'b0000);
    check("single idle", 32'(valid[0]), 32'd0);

    // Handoff from owner 1 to 3.
    step(4'b0010, 4'b0000);
    step(4'b1010, 4'b0000);
    step(4'b1000, 4'b0000);
    check("handoff gnt", 32'(gnt[0]), 32'h8);
    check("handoff sel", 32'({s1[0], s0[0]}), 32'h3);
    check("handoff cnt", 32'(cnt[0]), 32'd0);
    step(4'b0000, 4'b0000);

    // Lone requester past the hold limit.
    for (int n = 0; n < 20; n++) step(4'b0001, 4'b0000);
    check("timeout cnt", 32'(cnt[0]), 32'd3);
    check("timeout valid", 32'(valid[0]), 32'd1);
    step(4'b0000, 4'b0000);

    // Full contention rotation, with d0..d3 = 0,1,0,1 feeding the mux.
    for (int n = 0; n < 16; n++) step(4'b1111, 4'b1010);

    // Randomised requests and data.
    for (int n = 0; n < 400; n++) step(4'($urandom), 4'($urandom));

    // Asynchronous reset in the middle of a grant.
    for (int n = 0; n < 3; n++) step(4'b1111, 4'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst gnt", 32'(gnt[0]), 32'h0);
    check("rst valid", 32'(valid[0]), 32'd0);
    check("rst sel", 32'({s1[0], s0[0]}), 32'h0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) step(4'b1111, 4'b0101);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
